// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register with write-back mux, halt latch and retire counter
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        reg_write_in,
  input  logic        mem_to_reg_in,
  input  logic        pc_to_reg_in,
  input  logic        halt_in,
  input  logic [3:0]  dst_reg_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] mem_data_in,
  input  logic [15:0] pc_plus2_in,
  input  logic        stall,
  input  logic        flush,
  output logic        wb_write_en,
  output logic [15:0] wb_write_onehot,
  output logic [3:0]  wb_dst_reg,
  output logic [15:0] wb_data,
  output logic        wb_valid,
  output logic        halted,
  output logic [15:0] retire_count
);

  logic        valid_q,      valid_d;
  logic        reg_write_q,  reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        pc_to_reg_q,  pc_to_reg_d;
  logic        halt_q,       halt_d;
  logic [3:0]  dst_q,        dst_d;
  logic [15:0] alu_q,        alu_d;
  logic [15:0] mem_q,        mem_d;
  logic [15:0] pc2_q,        pc2_d;
  logic        halted_q,     halted_d;
  logic [15:0] retire_q,     retire_d;

  always_comb begin
    valid_d      = valid_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    pc_to_reg_d  = pc_to_reg_q;
    halt_d       = halt_q;
    dst_d        = dst_q;
    alu_d        = alu_q;
    mem_d        = mem_q;
    pc2_d        = pc2_q;
    // Flush only needs to kill valid; the remaining fields are don't-care.
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d      = valid_in;
      reg_write_d  = reg_write_in;
      mem_to_reg_d = mem_to_reg_in;
      pc_to_reg_d  = pc_to_reg_in;
      halt_d       = halt_in;
      dst_d        = dst_reg_in;
      alu_d        = alu_result_in;
      mem_d        = mem_data_in;
      pc2_d        = pc_plus2_in;
    end
  end

  always_comb begin
    halted_d = halted_q | (valid_q & halt_q);
    retire_d = retire_q;
    // The entry is counted as it leaves, so a stalled entry retires only once.
    if (valid_q && !stall && !halted_q) begin
      retire_d = retire_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      pc_to_reg_q  <= 1'b0;
      halt_q       <= 1'b0;
      dst_q        <= 4'd0;
      alu_q        <= 16'd0;
      mem_q        <= 16'd0;
      pc2_q        <= 16'd0;
      halted_q     <= 1'b0;
      retire_q     <= 16'd0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      pc_to_reg_q  <= pc_to_reg_d;
      halt_q       <= halt_d;
      dst_q        <= dst_d;
      alu_q        <= alu_d;
      mem_q        <= mem_d;
      pc2_q        <= pc2_d;
      halted_q     <= halted_d;
      retire_q     <= retire_d;
    end
  end

  always_comb begin
    if (pc_to_reg_q) begin
      wb_data = pc2_q;
    end else if (mem_to_reg_q) begin
      wb_data = mem_q;
    end else begin
      wb_data = alu_q;
    end
  end

  // A latched HLT never writes, and nothing writes once the core has halted.
  assign wb_write_en     = valid_q & reg_write_q & (dst_q != 4'd0) & ~halt_q & ~halted_q;
  assign wb_write_onehot = wb_write_en ? (16'h0001 << dst_q) : 16'h0000;
  assign wb_dst_reg      = dst_q;
  assign wb_valid        = valid_q;
  assign halted          = halted_q;
  assign retire_count    = retire_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-low.
REQ-003 valid_in  in  1  MEM-stage entry is a real instruction.
REQ-004 reg_write_in  in  1  instruction writes a register.
REQ-005 mem_to_reg_in  in  1  write data selects the memory load result.
REQ-006 pc_to_reg_in  in  1  write data selects PC+2 (PCS instruction).
REQ-007 halt_in  in  1  instruction is HLT.
REQ-008 dst_reg_in  in  4  destination register number.
REQ-009 alu_result_in, mem_data_in, pc_plus2_in  in  16 each  candidate write data.
REQ-010 stall  in  1  hold the current entry.
REQ-011 flush  in  1  squash the incoming entry.
REQ-012 wb_write_en  out  1  register-file write strobe.
REQ-013 wb_write_onehot  out  16  decoded per-register write enable (bit n = register n).
REQ-014 wb_dst_reg  out  4  latched destination.
REQ-015 wb_data  out  16  register-file write data (also the forwarding value).
REQ-016 wb_valid  out  1  latched entry valid.
REQ-017 halted  out  1  sticky processor-halted flag.
REQ-018 retire_count  out  16  retired-instruction counter.

Function
REQ-019 The stage SHALL be one pipeline register; outputs are combinational from the latched entry only (no input-to-output paths).
REQ-020 Rising edge, flush=1: the entry SHALL be cleared (valid=0, other fields don't-care), regardless of stall.
REQ-021 Rising edge, flush=0, stall=1: the entry SHALL hold unchanged.
REQ-022 Rising edge, flush=0, stall=0: all *_in fields SHALL be latched.
REQ-023 wb_data SHALL be pc_plus2 if pc_to_reg, else mem_data if mem_to_reg, else alu_result (from latched fields; pc_to_reg has priority).
REQ-024 wb_write_en SHALL be valid & reg_write & (dst_reg != 0) & !halted; writes to R0 are suppressed.
REQ-025 wb_write_onehot SHALL equal (1 << dst_reg) when wb_write_en=1, else all zeros; never more than one bit set.
REQ-026 halted SHALL set at the rising edge on which the latched entry is valid with halt=1, and SHALL stay set until reset.
REQ-027 A valid HLT entry SHALL not itself write a register, even if reg_write=1.
REQ-028 While halted=1: wb_write_en=0, retire_count frozen, and new entries still latch but have no effect.
REQ-029 retire_count SHALL increment by 1 at each rising edge where the latched entry is valid, stall=0 and halted=0 (counted when the entry leaves, so a stalled entry counts once); the HLT entry counts.
REQ-030 retire_count SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-031 An entry latched with valid_in=0 SHALL produce no write and no count, whatever its other fields.

Reset
REQ-032 rst low SHALL immediately, without clk: valid=0, all latched fields 0, halted=0, retire_count=0; hence wb_write_en=0, wb_write_onehot=0, wb_data=0, wb_dst_reg=0.
REQ-033 Reset mid-stall or mid-halt SHALL clear state identically; the first edge after rst rises SHALL follow REQ-020..022.

Verification
REQ-034 ALU write: valid, reg_write, dst=5, alu=0x1234, no stall -> after one edge wb_write_en=1, onehot=0x0020, wb_data=0x1234; retire_count 0 -> 1 on the next edge.
REQ-035 Mux priority: pc_to_reg=1, mem_to_reg=1, pc_plus2=0x0042, mem=0xBEEF -> wb_data=0x0042; clear pc_to_reg -> 0xBEEF.
REQ-036 Stall 3 cycles holding dst=3 entry, then flush and stall together -> wb_write_en stays 1 through the stall, retire_count +0 during the stall; flush edge gives valid=0; total count +0 (a flushed-while-stalled entry does not retire).
REQ-037 R0 write: valid, reg_write, dst=0 -> wb_write_en=0, onehot=0, retire_count still +1.
REQ-038 HLT with reg_write=1 then ADD to R7 -> no write for either, halted=1 one edge after HLT latches, retire_count +1 only, frozen afterwards.
REQ-039 Preload 0xFFFF retirements, one more -> retire_count=0x0000; assert rst low between edges -> all outputs 0 immediately.
